cmn_free_list: RTL and testbench

- Owns the free/busy state of a pool of ENTRY_NUM entries, for example physical registers or buffer slots.
- Grants up to ALLOC_NUM allocations per cycle, lowest free index first, and accepts up to REL_NUM releases per cycle.
- It is the allocation/deallocation owner: it holds the registered free vector and hands back indices that consumers later return.
- Includes a flush path for pipeline recovery and a sticky error flag for illegal releases.

---
 rtl/cmn_free_list_if.sv | 31 +++
 rtl/cmn_free_list.sv | 120 ++++++++++++
 tb/tb_cmn_free_list.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmn_free_list_if.sv
// Allocation/release bus of the free-list pool. The master side is the consumer
// that requests and returns entries; the slave side is the free list itself.
interface cmn_free_list_if #(
  parameter int ENTRY_NUM = 16,
  parameter int ALLOC_NUM = 4,
  parameter int REL_NUM   = 4
);
  localparam int AWIDTH = $clog2(ENTRY_NUM);
  localparam int CWIDTH = $clog2(ENTRY_NUM + 1);

  logic [ALLOC_NUM-1:0]                 alloc_req;
  logic [ALLOC_NUM-1:0]                 alloc_gnt;
  logic [ALLOC_NUM-1:0][ENTRY_NUM-1:0]  alloc_idx_oh;
  logic [ALLOC_NUM-1:0][AWIDTH-1:0]     alloc_idx_bin;
  logic [REL_NUM-1:0]                   rel_vld;
  logic [REL_NUM-1:0][AWIDTH-1:0]       rel_idx_bin;
  logic                                 flush;
  logic [CWIDTH-1:0]                    free_cnt;
  logic                                 empty;
  logic                                 err_dbl_free;

  modport master (
    output alloc_req, rel_vld, rel_idx_bin, flush,
    input  alloc_gnt, alloc_idx_oh, alloc_idx_bin, free_cnt, empty, err_dbl_free
  );

  modport slave (
    input  alloc_req, rel_vld, rel_idx_bin, flush,
    output alloc_gnt, alloc_idx_oh, alloc_idx_bin, free_cnt, empty, err_dbl_free
  );
endinterface

// File: rtl/cmn_free_list.sv
// Free-list owner for a pool of ENTRY_NUM entries: grants up to ALLOC_NUM lowest
// free indices per cycle, accepts REL_NUM releases, supports flush and flags bad releases.
module cmn_free_list #(
  parameter int ENTRY_NUM = 16,
  parameter int ALLOC_NUM = 4,
  parameter int REL_NUM   = 4
) (
  input  logic           clk,
  input  logic           rst,
  cmn_free_list_if.slave bus
);
  localparam int AWIDTH = $clog2(ENTRY_NUM);
  localparam int CWIDTH = $clog2(ENTRY_NUM + 1);
  localparam logic [ENTRY_NUM-1:0] ONE_V = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

  function automatic logic [ENTRY_NUM-1:0] lowest_one(input logic [ENTRY_NUM-1:0] v);
    return v & (~v + ONE_V);
  endfunction

  function automatic logic [AWIDTH-1:0] oh2bin(input logic [ENTRY_NUM-1:0] oh);
    logic [AWIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      b = b | (oh[i] ? AWIDTH'(i) : {AWIDTH{1'b0}});
    end
    return b;
  endfunction

  function automatic logic [CWIDTH-1:0] popcount(input logic [ENTRY_NUM-1:0] v);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      c = c + CWIDTH'(v[i]);
    end
    return c;
  endfunction

  logic [ENTRY_NUM-1:0]                free_vec_q, free_vec_d;
  logic [CWIDTH-1:0]                   free_cnt_q, free_cnt_d;
  logic                                empty_q;
  logic                                err_q, err_d;
  logic [ENTRY_NUM-1:0]                srch_s;
  logic [ALLOC_NUM-1:0][ENTRY_NUM-1:0] cand_oh_s;
  logic [ALLOC_NUM-1:0][AWIDTH-1:0]    cand_bin_s;
  logic [ALLOC_NUM-1:0]                cand_vld_s;
  logic [ALLOC_NUM-1:0]                gnt_s;
  logic [ENTRY_NUM-1:0]                alloc_mask_s;
  logic [ENTRY_NUM-1:0]                rel_mask_s;
  logic [ENTRY_NUM-1:0]                rel_oh_s;
  logic                                rel_err_s;
  logic                                in_range_s;

  // Candidate k is the k-th lowest free entry: peel off the lowest set bit each step.
  always_comb begin
    srch_s     = free_vec_q;
    cand_oh_s  = '0;
    cand_bin_s = '0;
    cand_vld_s = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      cand_vld_s[k] = |srch_s;
      cand_oh_s[k]  = lowest_one(srch_s);
      cand_bin_s[k] = oh2bin(cand_oh_s[k]);
      srch_s        = srch_s & ~cand_oh_s[k];
    end
  end

  // Per-lane grant and the set of entries taken this cycle.
  always_comb begin
    gnt_s        = bus.alloc_req & cand_vld_s & {ALLOC_NUM{~bus.flush}};
    alloc_mask_s = '0;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      alloc_mask_s = alloc_mask_s | (gnt_s[i] ? cand_oh_s[i] : {ENTRY_NUM{1'b0}});
    end
  end

  // Release mask; a release of an already-free, duplicated or out-of-range index is an error.
  always_comb begin
    rel_mask_s = '0;
    rel_oh_s   = '0;
    rel_err_s  = 1'b0;
    in_range_s = 1'b0;
    for (int j = 0; j < REL_NUM; j++) begin
      in_range_s = ({{(32-AWIDTH){1'b0}}, bus.rel_idx_bin[j]} < 32'(ENTRY_NUM));
      rel_oh_s   = (bus.rel_vld[j] && in_range_s) ? (ONE_V << bus.rel_idx_bin[j])
                                                  : {ENTRY_NUM{1'b0}};
      rel_err_s  = rel_err_s | (bus.rel_vld[j] & ~in_range_s)
                 | (|(rel_oh_s & (free_vec_q | rel_mask_s)));
      rel_mask_s = rel_mask_s | rel_oh_s;
    end
  end

  // Next pool state; flush overrides both grants and releases.
  always_comb begin
    free_vec_d = bus.flush ? {ENTRY_NUM{1'b1}} : ((free_vec_q & ~alloc_mask_s) | rel_mask_s);
    free_cnt_d = popcount(free_vec_d);
    err_d      = err_q | (rel_err_s & ~bus.flush);
  end

  // Pool state, count and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_vec_q <= {ENTRY_NUM{1'b1}};
      free_cnt_q <= CWIDTH'(ENTRY_NUM);
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      free_vec_q <= free_vec_d;
      free_cnt_q <= free_cnt_d;
      empty_q    <= (free_cnt_d == {CWIDTH{1'b0}});
      err_q      <= err_d;
    end
  end

  assign bus.alloc_gnt     = gnt_s;
  assign bus.alloc_idx_oh  = cand_oh_s;
  assign bus.alloc_idx_bin = cand_bin_s;
  assign bus.free_cnt      = free_cnt_q;
  assign bus.empty         = empty_q;
  assign bus.err_dbl_free  = err_q;
endmodule

// File: tb/tb_cmn_free_list.sv
// Self-checking bench for cmn_free_list: directed scenarios plus randomized traffic
// checked against a set-of-free-entries reference model.
module tb_cmn_free_list;
  localparam int N = 16;
  localparam int A = 4;
  localparam int R = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bit   mfree [N];
  bit   merr;
  logic [A-1:0] exp_gnt;
  int   exp_bin [A];
  bit   exp_vld [A];

  cmn_free_list_if #(.ENTRY_NUM(N), .ALLOC_NUM(A), .REL_NUM(R)) bus ();

  cmn_free_list #(.ENTRY_NUM(N), .ALLOC_NUM(A), .REL_NUM(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mcount();
    int c;
    c = 0;
    for (int e = 0; e < N; e++) c += mfree[e];
    return c;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < N; e++) mfree[e] = 1'b1;
    merr = 1'b0;
  endtask

  // Apply inputs at the falling edge and derive the expected combinational outputs.
  task automatic drive(input logic [A-1:0] req, input logic [R-1:0] rv,
                       input logic [3:0] i0, input logic [3:0] i1,
                       input logic [3:0] i2, input logic [3:0] i3, input logic fl);
    int q[$];
    @(negedge clk);
    bus.alloc_req      = req;
    bus.rel_vld        = rv;
    bus.rel_idx_bin[0] = i0;
    bus.rel_idx_bin[1] = i1;
    bus.rel_idx_bin[2] = i2;
    bus.rel_idx_bin[3] = i3;
    bus.flush          = fl;
    for (int e = 0; e < N; e++) if (mfree[e]) q.push_back(e);
    for (int k = 0; k < A; k++) begin
      exp_vld[k] = (k < q.size());
      exp_bin[k] = exp_vld[k] ? q[k] : 0;
      exp_gnt[k] = req[k] && exp_vld[k] && !fl;
    end
    #1;
  endtask

  // Advance the model by one cycle and let the clock edge happen.
  task automatic tick();
    bit pre [N];
    int seen[$];
    int idx;
    pre = mfree;
    if (bus.flush) begin
      for (int e = 0; e < N; e++) mfree[e] = 1'b1;
    end else begin
      for (int k = 0; k < A; k++) if (exp_gnt[k]) mfree[exp_bin[k]] = 1'b0;
      for (int j = 0; j < R; j++) begin
        if (bus.rel_vld[j]) begin
          idx = int'(bus.rel_idx_bin[j]);
          if (idx >= N) merr = 1'b1;
          else begin
            if (pre[idx]) merr = 1'b1;
            foreach (seen[s]) if (seen[s] == idx) merr = 1'b1;
            seen.push_back(idx);
            mfree[idx] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.alloc_req = '0; bus.rel_vld = '0; bus.rel_idx_bin = '0; bus.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.free_cnt !== 5'd16) $display("FAIL reset_cnt got %0d exp 16", bus.free_cnt); else n_pass++;
    n_checks++;
    if (bus.empty !== 1'b0) $display("FAIL reset_empty got %b exp 0", bus.empty); else n_pass++;
    n_checks++;
    if (bus.err_dbl_free !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err_dbl_free); else n_pass++;
    n_checks++;
    if (bus.alloc_gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", bus.alloc_gnt); else n_pass++;
    for (int k = 0; k < A; k++) begin
      n_checks++;
      if (bus.alloc_idx_bin[k] !== 4'(k)) $display("FAIL reset_idx lane%0d got %0d exp %0d", k, bus.alloc_idx_bin[k], k);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_alloc_basic();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_gnt !== 4'b1111) $display("FAIL basic_gnt got %b exp 1111", bus.alloc_gnt); else n_pass++;
    for (int k = 0; k < A; k++) begin
      n_checks++;
      if (bus.alloc_idx_oh[k] !== (16'h0001 << k)) $display("FAIL basic_oh lane%0d got %h exp %h", k, bus.alloc_idx_oh[k], 16'h0001 << k);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.free_cnt !== 5'd12) $display("FAIL basic_cnt got %0d exp 12", bus.free_cnt); else n_pass++;
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < A; k++) begin
      n_checks++;
      if (bus.alloc_idx_bin[k] !== 4'(k + 4)) $display("FAIL basic_idx2 lane%0d got %0d exp %0d", k, bus.alloc_idx_bin[k], k + 4);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_fill_to_empty();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    drive(4'b0011, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_gnt !== 4'b0011) $display("FAIL partial_gnt got %b exp 0011", bus.alloc_gnt); else n_pass++;
    n_checks++;
    if (bus.alloc_idx_bin[0] !== 4'd14 || bus.alloc_idx_bin[1] !== 4'd15)
      $display("FAIL partial_idx got %0d,%0d exp 14,15", bus.alloc_idx_bin[0], bus.alloc_idx_bin[1]);
    else n_pass++;
    n_checks++;
    if (bus.alloc_idx_oh[2] !== 16'h0000 || bus.alloc_idx_bin[3] !== 4'd0)
      $display("FAIL partial_invalid_lane got oh2=%h bin3=%0d exp 0,0", bus.alloc_idx_oh[2], bus.alloc_idx_bin[3]);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.empty !== 1'b1 || bus.free_cnt !== 5'd0)
      $display("FAIL empty_state got empty=%b cnt=%0d exp 1,0", bus.empty, bus.free_cnt);
    else n_pass++;
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_gnt !== 4'b0000) $display("FAIL empty_gnt got %b exp 0000", bus.alloc_gnt); else n_pass++;
    tick();
  endtask

  task automatic test_release_from_empty();
    drive(4'b0001, 4'b0011, 4'd5, 4'd9, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_gnt !== 4'b0000) $display("FAIL nobypass_gnt got %b exp 0000", bus.alloc_gnt); else n_pass++;
    tick();
    n_checks++;
    if (bus.free_cnt !== 5'd2) $display("FAIL rel_cnt got %0d exp 2", bus.free_cnt); else n_pass++;
    drive(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_idx_bin[0] !== 4'd5 || bus.alloc_idx_bin[1] !== 4'd9)
      $display("FAIL rel_idx got %0d,%0d exp 5,9", bus.alloc_idx_bin[0], bus.alloc_idx_bin[1]);
    else n_pass++;
    n_checks++;
    if (bus.err_dbl_free !== 1'b0) $display("FAIL rel_err got %b exp 0", bus.err_dbl_free); else n_pass++;
    tick();
  endtask

  task automatic test_alloc_and_release();
    do_reset();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    drive(4'b0000, 4'b0011, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0); tick();
    drive(4'b0011, 4'b0001, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (bus.alloc_gnt !== 4'b0011 || bus.alloc_idx_bin[0] !== 4'd0 || bus.alloc_idx_bin[1] !== 4'd1)
      $display("FAIL mix_gnt got %b idx %0d,%0d exp 0011 idx 0,1", bus.alloc_gnt, bus.alloc_idx_bin[0], bus.alloc_idx_bin[1]);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.free_cnt !== 5'd9) $display("FAIL mix_cnt got %0d exp 9", bus.free_cnt); else n_pass++;
    n_checks++;
    if (bus.err_dbl_free !== 1'b0) $display("FAIL mix_err got %b exp 0", bus.err_dbl_free); else n_pass++;
  endtask

  task automatic test_double_free();
    do_reset();
    drive(4'b0000, 4'b0001, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    n_checks++;
    if (bus.err_dbl_free !== 1'b1) $display("FAIL dbl_free_err got %b exp 1", bus.err_dbl_free); else n_pass++;
    n_checks++;
    if (bus.free_cnt !== 5'd16) $display("FAIL dbl_free_cnt got %0d exp 16", bus.free_cnt); else n_pass++;
    repeat (3) begin
      drive(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    end
    n_checks++;
    if (bus.err_dbl_free !== 1'b1) $display("FAIL dbl_free_sticky got %b exp 1", bus.err_dbl_free); else n_pass++;
    do_reset();
    repeat (3) begin
      drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    end
    n_checks++;
    if (bus.err_dbl_free !== 1'b0) $display("FAIL dup_pre_err got %b exp 0", bus.err_dbl_free); else n_pass++;
    drive(4'b0000, 4'b0011, 4'd8, 4'd8, 4'd0, 4'd0, 1'b0); tick();
    n_checks++;
    if (bus.err_dbl_free !== 1'b1) $display("FAIL dup_lane_err got %b exp 1", bus.err_dbl_free); else n_pass++;
    n_checks++;
    if (bus.free_cnt !== 5'd5) $display("FAIL dup_lane_cnt got %0d exp 5", bus.free_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    drive(4'b1111, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    drive(4'b0011, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    n_checks++;
    if (bus.free_cnt !== 5'd6) $display("FAIL flush_pre_cnt got %0d exp 6", bus.free_cnt); else n_pass++;
    drive(4'b1111, 4'b0011, 4'd2, 4'd12, 4'd0, 4'd0, 1'b1);
    n_checks++;
    if (bus.alloc_gnt !== 4'b0000) $display("FAIL flush_gnt got %b exp 0000", bus.alloc_gnt); else n_pass++;
    tick();
    n_checks++;
    if (bus.free_cnt !== 5'd16) $display("FAIL flush_cnt got %0d exp 16", bus.free_cnt); else n_pass++;
    n_checks++;
    if (bus.err_dbl_free !== 1'b0) $display("FAIL flush_err got %b exp 0", bus.err_dbl_free); else n_pass++;
    drive(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < A; k++) begin
      n_checks++;
      if (bus.alloc_idx_bin[k] !== 4'(k)) $display("FAIL flush_idx lane%0d got %0d exp %0d", k, bus.alloc_idx_bin[k], k);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(4'b1111, 4'b0001, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0); tick();
    n_checks++;
    if (bus.err_dbl_free !== 1'b1 || bus.free_cnt !== 5'd12)
      $display("FAIL mid_pre got err=%b cnt=%0d exp 1,12", bus.err_dbl_free, bus.free_cnt);
    else n_pass++;
    @(negedge clk);
    bus.alloc_req = '0; bus.rel_vld = '0; bus.flush = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.free_cnt !== 5'd16 || bus.err_dbl_free !== 1'b0 || bus.empty !== 1'b0)
      $display("FAIL mid_rst got cnt=%0d err=%b empty=%b exp 16,0,0", bus.free_cnt, bus.err_dbl_free, bus.empty);
    else n_pass++;
    n_checks++;
    if (bus.alloc_idx_bin[3] !== 4'd3) $display("FAIL mid_rst_idx got %0d exp 3", bus.alloc_idx_bin[3]); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [A-1:0] req;
    logic [R-1:0] rv;
    logic [3:0]   ri [R];
    logic         fl;
    int           busy[$];
    int           p;
    logic [N-1:0] eo;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      busy.delete();
      for (int e = 0; e < N; e++) if (!mfree[e]) busy.push_back(e);
      req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'((1 << $urandom_range(0, 4)) - 1);
      rv  = '0;
      for (int j = 0; j < R; j++) begin
        ri[j] = 4'd0;
        if ($urandom_range(0, 40) == 0) begin
          rv[j] = 1'b1; ri[j] = 4'($urandom_range(0, N - 1));
        end else if (busy.size() > 0 && $urandom_range(0, 2) == 0) begin
          p = $urandom_range(0, busy.size() - 1);
          rv[j] = 1'b1; ri[j] = 4'(busy[p]);
          busy.delete(p);
        end
      end
      fl = ($urandom_range(0, 31) == 0);
      drive(req, rv, ri[0], ri[1], ri[2], ri[3], fl);
      n_checks++;
      if (bus.alloc_gnt !== exp_gnt) $display("FAIL rnd_gnt cyc%0d got %b exp %b", c, bus.alloc_gnt, exp_gnt); else n_pass++;
      for (int k = 0; k < A; k++) begin
        eo = exp_vld[k] ? (16'h0001 << exp_bin[k]) : 16'h0000;
        n_checks++;
        if (bus.alloc_idx_bin[k] !== 4'(exp_bin[k]) || bus.alloc_idx_oh[k] !== eo)
          $display("FAIL rnd_idx cyc%0d lane%0d got %0d/%h exp %0d/%h", c, k, bus.alloc_idx_bin[k], bus.alloc_idx_oh[k], exp_bin[k], eo);
        else n_pass++;
      end
      tick();
      n_checks++;
      if (bus.free_cnt !== 5'(mcount()) || bus.empty !== (mcount() == 0) || bus.err_dbl_free !== merr)
        $display("FAIL rnd_state cyc%0d got cnt=%0d empty=%b err=%b exp %0d,%b,%b",
                 c, bus.free_cnt, bus.empty, bus.err_dbl_free, mcount(), mcount() == 0, merr);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.alloc_req = '0; bus.rel_vld = '0; bus.rel_idx_bin = '0; bus.flush = 1'b0;
    model_reset();
    test_reset();
    test_alloc_basic();
    test_fill_to_empty();
    test_release_from_empty();
    test_alloc_and_release();
    test_double_free();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
